// File: rtl/biu_pkg.sv
// Shared bus interface unit types for the biu_master/biu_slave pair.
// Holds the master FSM states and the captured request bundle.
package biu_pkg;

   localparam int BIU_ADDR_W = 32;
   localparam int BIU_DATA_W = 32;
   localparam int BIU_BE_W   = BIU_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      XFER,
      RESP
   } biu_master_state_t;

   typedef struct packed {
      logic                  rnw;
      logic [BIU_ADDR_W-1:0] addr;
      logic [BIU_DATA_W-1:0] wdata;
      logic [BIU_BE_W-1:0]   byte_en;
   } biu_req_t;

endpackage

// File: rtl/biu_master.sv
// Bus initiator: captures one client request, arbitrates, runs a
// single transfer and reports completion, with timeout/alignment errors.
module biu_master
   import biu_pkg::*;
#(
   parameter int ADDR_WIDTH     = BIU_ADDR_W,
   parameter int DATA_WIDTH     = BIU_DATA_W,
   parameter int ALIGNED        = 1,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    biu_en,
   input  logic                    biu_rnw,
   input  logic [ADDR_WIDTH-1:0]   biu_addr,
   input  logic [DATA_WIDTH-1:0]   biu_wdata,
   input  logic [DATA_WIDTH/8-1:0] biu_byte_en,
   output logic                    biu_busy,
   output logic                    biu_done,
   output logic                    biu_error,
   output logic [DATA_WIDTH-1:0]   biu_rdata,
   output logic                    bus_req,
   input  logic                    bus_gnt,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH-1:0]   bus_wdata,
   output logic [DATA_WIDTH/8-1:0] bus_byte_en,
   output logic                    bus_read,
   output logic                    bus_write,
   input  logic [DATA_WIDTH-1:0]   bus_rdata,
   input  logic                    bus_ack
);

   localparam int BEW = DATA_WIDTH / 8;
   localparam int LSB = $clog2(BEW);
   localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << LSB) - 1);
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

   biu_master_state_t state_q, state_d;
   biu_req_t          req_q, req_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic req_o_q, req_o_d;
   logic rd_q, rd_d;
   logic wr_q, wr_d;
   logic misaligned;

   assign misaligned = (ALIGNED != 0) && ((biu_addr & AMASK) != '0);

   // Next-state, capture, timeout and output decode; outputs follow state_d
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (biu_en) begin
               req_d.rnw     = biu_rnw;
               req_d.addr    = BIU_ADDR_W'(biu_addr);
               req_d.wdata   = BIU_DATA_W'(biu_wdata);
               req_d.byte_en = biu_rnw ? '1 : BIU_BE_W'(biu_byte_en);
               state_d       = misaligned ? RESP : ARB;
               err_d         = misaligned;
            end
         end
         ARB: begin
            if (bus_gnt) state_d = XFER;
         end
         XFER: begin
            if (bus_ack) begin
               if (req_q.rnw) rdata_d = bus_rdata;
               state_d = RESP;
               cnt_d   = '0;
            end else if (TIMEOUT_CYCLES > 0) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == TO_LIM) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == RESP);
      req_o_d = (state_d == ARB) || (state_d == XFER);
      rd_d    = (state_d == XFER) && req_d.rnw;
      wr_d    = (state_d == XFER) && !req_d.rnw;
   end

   // State, request capture, counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_o_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         req_o_q <= req_o_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign biu_busy    = busy_q;
   assign biu_done    = done_q;
   assign biu_error   = err_q;
   assign biu_rdata   = rdata_q;
   assign bus_req     = req_o_q;
   assign bus_read    = rd_q;
   assign bus_write   = wr_q;
   assign bus_addr    = ADDR_WIDTH'(req_q.addr);
   assign bus_wdata   = DATA_WIDTH'(req_q.wdata);
   assign bus_byte_en = BEW'(req_q.byte_en);

endmodule

// File: doc/biu_master.md
Name: biu_master

Overview:
- Bus initiator: the counterpart of biu_slave on the same bus. Takes single-word read/write requests from a local client, arbitrates with req/gnt, then drives one bus transfer.
- Completes the transfer on slave ack, or on a timeout or alignment error.
- Sits between CPU/DMA-style clients and the shared bus that biu_slave instances decode.

Parameters:
- ADDR_WIDTH, 32, bus/client address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- ALIGNED, 1, 1 = reject addresses not aligned to DATA_WIDTH/8 bytes.
- TIMEOUT_CYCLES, 256, max cycles in XFER waiting for ack; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- biu_en  in  1  request strobe; accepted only when biu_busy=0
- biu_rnw  in  1  1=read, 0=write
- biu_addr  in  ADDR_WIDTH  byte address
- biu_wdata  in  DATA_WIDTH  write data
- biu_byte_en  in  DATA_WIDTH/8  write byte enables
- biu_busy  out  1  request in flight
- biu_done  out  1  one-cycle completion pulse
- biu_error  out  1  valid with biu_done; 1 = misaligned or timeout
- biu_rdata  out  DATA_WIDTH  last successful read data
- bus_req  out  1  arbitration request
- bus_gnt  in  1  arbitration grant
- bus_addr  out  ADDR_WIDTH  transfer address
- bus_wdata  out  DATA_WIDTH  write data
- bus_byte_en  out  DATA_WIDTH/8  byte enables; all ones on reads
- bus_read  out  1  read command
- bus_write  out  1  write command
- bus_rdata  in  DATA_WIDTH  read data; valid when bus_ack=1
- bus_ack  in  1  slave completion

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0, state IDLE, timeout counter 0, request registers 0.
  - Asserting rst mid-transfer drops bus_req/bus_read/bus_write immediately.
- All outputs are registered.
- IDLE:
  - biu_busy=0.
  - On biu_en=1, capture rnw/addr/wdata/byte_en; biu_busy=1 next cycle.
  - If ALIGNED=1 and the low log2(DATA_WIDTH/8) address bits are nonzero, go to RESP with error=1. No bus activity.
  - Otherwise go to ARB.
- ARB:
  - bus_req=1.
  - On sampling bus_gnt=1, go to XFER.
- XFER:
  - bus_req=1; bus_read or bus_write=1 per captured rnw.
  - bus_addr/bus_wdata/bus_byte_en driven from captured registers and held stable until the transfer ends.
  - Counter increments each XFER cycle.
  - On bus_ack=1: latch bus_rdata into biu_rdata if read; go to RESP with error=0.
  - If the counter reaches TIMEOUT_CYCLES with no ack (TIMEOUT_CYCLES>0): go to RESP with error=1; biu_rdata unchanged.
  - bus_gnt is ignored once in XFER; the master holds the bus until ack or timeout.
- RESP:
  - bus_req/bus_read/bus_write=0.
  - biu_done=1 for exactly one cycle, biu_error as determined, biu_busy=1.
  - Next state IDLE; counter cleared.
- Minimum latency, with gnt and ack already high:
  - biu_en sampled at edge 0.
  - bus_req at cycle 1; bus_read/write at cycle 2.
  - biu_done at cycle 3.
- Ack and cmd in the same cycle: the transfer lasts one XFER cycle.
- biu_en while biu_busy=1 is ignored; no queueing.
- bus_ack outside XFER is ignored.
- biu_rdata is unchanged by writes, errors and resets of other fields (reset clears it).
- biu_error is 0 whenever biu_done=0.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it does not run in ARB.

Decomposition:
- biu_pkg:
  - biu_master_state_t enum {IDLE, ARB, XFER, RESP}.
  - Request struct (rnw, addr, wdata, byte_en), parameterised via localparams matching the widths.
  - Shared with the biu_slave side.
- No sub-module: the FSM, capture registers and timeout counter stay inline in biu_master.

Test Plan:
- Read, gnt=1 and ack=1 immediate, addr 0x80000000, bus_rdata 0xDEADBEEF -> bus_read high only in cycle 2; biu_done=1 and biu_rdata=0xDEADBEEF at cycle 3; biu_error=0.
- Write, addr 0x80000004, data 0x12345678, byte_en 0x3, gnt after 2 cycles, ack after 3 XFER cycles -> bus_write high 3 cycles with stable addr/data/byte_en 0x3; single biu_done pulse; biu_rdata unchanged.
- ALIGNED=1, read 0x80000002 -> biu_done=1, biu_error=1 at cycle 1; bus_req never asserted. Same access with ALIGNED=0 completes normally.
- TIMEOUT_CYCLES=8, gnt=1, ack never -> bus_read high exactly 8 cycles, then biu_done=1, biu_error=1; biu_rdata keeps its prior value 0xDEADBEEF.
- biu_en pulsed every cycle during a transfer -> only the first request is executed; next accepted the cycle after return to IDLE. Ack pulses in IDLE are ignored.
- rst asserted mid-XFER -> bus_read/bus_req/biu_busy drop to 0 without a clock edge; after release, a fresh read completes with 3-cycle latency.
